// File: rtl/ride_dispatch_ctrl_if.sv
// Passenger-side and display-side signal bundle for ride_dispatch_ctrl.
// The master modport is the passenger/key side, the slave modport is the controller.
interface ride_dispatch_ctrl_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] orig;
  logic [4*N_REQ-1:0] dest;
  logic               accept;
  logic               cancel;
  logic [N_REQ-1:0]   grant;
  logic [8:0]         posicao;
  logic               quote_valid;
  logic [3:0]         car_pos;
  logic [2:0]         state;
  logic               trip_done;
  logic               err;

  modport master (
    output req, orig, dest, accept, cancel,
    input  grant, posicao, quote_valid, car_pos, state, trip_done, err
  );

  modport slave (
    input  req, orig, dest, accept, cancel,
    output grant, posicao, quote_valid, car_pos, state, trip_done, err
  );
endinterface

// File: rtl/ride_dispatch_ctrl.sv
// Round-robin ride dispatcher: arbitrates passengers, shows the fare quote, moves the car.
// Optional macro PREMIUM_PRIO_EN gives req[0] absolute priority in arbitration.
module ride_dispatch_ctrl #(
  parameter int N_REQ     = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int ACCEPT_TO = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  ride_dispatch_ctrl_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int DW = $clog2(TICK_DIV);
  localparam int TW = $clog2(ACCEPT_TO + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    QUOTE     = 3'd1,
    WAIT_ACC  = 3'd2,
    TO_PICKUP = 3'd3,
    TRIP      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t           st;
  logic [N_REQ-1:0] grant_r;
  logic [8:0]       posicao_r;
  logic             quote_valid_r;
  logic [3:0]       car_r;
  logic [3:0]       orig_r;
  logic [3:0]       dest_r;
  logic             trip_done_r;
  logic             err_r;
  logic [PW-1:0]    rr;
  logic [PW-1:0]    owner;
  logic [DW-1:0]    presc;
  logic [TW-1:0]    to_cnt;

  logic             tick;
  logic             found;
  logic [PW-1:0]    win;
  logic [3:0]       win_orig;
  logic [3:0]       win_dest;
  logic             to_idle;

  function automatic logic [PW-1:0] rr_after(input logic [PW-1:0] o);
    return (int'(o) == N_REQ - 1) ? '0 : o + 1'b1;
  endfunction

  assign tick = (presc == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= tick ? '0 : presc + 1'b1;
  end

  // Scan from the round-robin pointer upward; the first requester found owns the car.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
`ifdef PREMIUM_PRIO_EN
    if (bus.req[0]) begin
      found = 1'b1;
      win   = '0;
    end
`else
`endif
    win_orig = bus.orig[int'(win)*4 +: 4];
    win_dest = bus.dest[int'(win)*4 +: 4];
  end

  always_comb begin
    to_idle = 1'b0;
    if (st == WAIT_ACC)
      to_idle = bus.cancel ||
                (!bus.accept && tick && (to_cnt == TW'(ACCEPT_TO - 1)));
    else if (st == TO_PICKUP)
      to_idle = bus.cancel;
    else if (st == DONE)
      to_idle = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      grant_r       <= '0;
      posicao_r     <= '0;
      quote_valid_r <= 1'b0;
      car_r         <= '0;
      orig_r        <= '0;
      dest_r        <= '0;
      trip_done_r   <= 1'b0;
      err_r         <= 1'b0;
      rr            <= '0;
      owner         <= '0;
      to_cnt        <= '0;
    end else begin
      trip_done_r <= 1'b0;
      err_r       <= 1'b0;
      unique case (st)
        IDLE: begin
          if (found) begin
            if (win_orig > 4'd8 || win_dest > 4'd8 || win_orig == win_dest) begin
              err_r <= 1'b1;
              rr    <= rr_after(win);
            end else begin
              orig_r  <= win_orig;
              dest_r  <= win_dest;
              owner   <= win;
              grant_r <= N_REQ'(1) << win;
              st      <= QUOTE;
            end
          end
        end
        QUOTE: begin
          posicao_r     <= (9'd1 << orig_r) | (9'd1 << dest_r);
          quote_valid_r <= 1'b1;
          to_cnt        <= '0;
          st            <= WAIT_ACC;
        end
        WAIT_ACC: begin
          if (!bus.cancel) begin
            if (bus.accept) st <= TO_PICKUP;
            else if (tick)  to_cnt <= to_cnt + 1'b1;
          end
        end
        TO_PICKUP: begin
          if (car_r == orig_r) st <= TRIP;
          else if (tick)       car_r <= (car_r < orig_r) ? car_r + 4'd1 : car_r - 4'd1;
        end
        TRIP: begin
          if (car_r == dest_r) begin
            st          <= DONE;
            trip_done_r <= 1'b1;
          end else if (tick) begin
            car_r <= (car_r < dest_r) ? car_r + 4'd1 : car_r - 4'd1;
          end
        end
        DONE: ;
        default: st <= IDLE;
      endcase
      // Every way back to IDLE blanks the quote and passes priority to the next port.
      if (to_idle) begin
        st            <= IDLE;
        grant_r       <= '0;
        posicao_r     <= '0;
        quote_valid_r <= 1'b0;
        rr            <= rr_after(owner);
      end
    end
  end

  assign bus.grant       = grant_r;
  assign bus.posicao     = posicao_r;
  assign bus.quote_valid = quote_valid_r;
  assign bus.car_pos     = car_r;
  assign bus.state       = st;
  assign bus.trip_done   = trip_done_r;
  assign bus.err         = err_r;
endmodule

// File: tb/tb_ride_dispatch_ctrl.sv
// Self-checking bench for ride_dispatch_ctrl with a transaction-level reference model.
// Honours PREMIUM_PRIO_EN in its arbitration model when the macro is defined.
module tb_ride_dispatch_ctrl;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int AT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ride_dispatch_ctrl_if #(.N_REQ(N)) bus();

  ride_dispatch_ctrl #(.N_REQ(N), .TICK_DIV(TD), .ACCEPT_TO(AT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int rr_model = 0;
  int car_model = 0;

  function automatic int model_pick(input int rr, input logic [3:0] r);
`ifdef PREMIUM_PRIO_EN
    if (r[0]) return 0;
`else
`endif
    for (int k = 0; k < N; k++)
      if (r[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic idle_inputs();
    bus.req    = '0;
    bus.orig   = '0;
    bus.dest   = '0;
    bus.accept = 1'b0;
    bus.cancel = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.state !== s) begin
      errors++;
      $display("[TB] FAIL %s: state %0d, wanted %0d within %0d cycles", name, bus.state, s, budget);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.grant, bus.posicao, bus.quote_valid, bus.car_pos, bus.state, bus.trip_done, bus.err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: grant=%b posicao=%b qv=%b car=%0d state=%0d td=%b err=%b, wanted all 0",
               bus.grant, bus.posicao, bus.quote_valid, bus.car_pos, bus.state, bus.trip_done, bus.err);
    end
    rst_n = 1'b1;
    rr_model = 0;
    car_model = 0;
    @(negedge clk);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_idle: state %0d, wanted 0", bus.state);
    end
  endtask

  // action: 0 = accept and ride, 1 = cancel+accept together in WAIT_ACC, 2 = let the quote time out
  task automatic run_txn(input logic [3:0] rq, input logic [15:0] o, input logic [15:0] d,
                         input int action, input bit always_cancel, input string name);
    int w, wo, wd, cnt, p, prev, ex, n;
    bit valid, done_seen;
    logic [3:0] exp_grant;
    logic [8:0] exp_pos;
    int path[$];
    wait_state(3'd0, 200, {name, "_idle"});
    w  = model_pick(rr_model, rq);
    wo = int'(o[4*w +: 4]);
    wd = int'(d[4*w +: 4]);
    valid = (wo <= 8) && (wd <= 8) && (wo != wd);
    bus.req  = rq;
    bus.orig = o;
    bus.dest = d;
    @(negedge clk);
    bus.req  = '0;
    bus.orig = 16'($urandom);
    bus.dest = 16'($urandom);
    if (!valid) begin
      checks++;
      if (bus.err !== 1'b1 || bus.grant !== '0 || bus.state !== 3'd0) begin
        errors++;
        $display("[TB] FAIL %s_reject: err=%b grant=%b state=%0d, wanted err=1 grant=0 state=0",
                 name, bus.err, bus.grant, bus.state);
      end
      rr_model = (w + 1) % N;
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_err_pulse: err=%b, wanted 0", name, bus.err);
      end
      return;
    end
    exp_grant = 4'(1 << w);
    exp_pos   = 9'(1 << wo) | 9'(1 << wd);
    checks++;
    if (bus.grant !== exp_grant || bus.state !== 3'd1) begin
      errors++;
      $display("[TB] FAIL %s_grant: grant=%b state=%0d, wanted grant=%b state=1", name, bus.grant, bus.state, exp_grant);
    end
    @(negedge clk);
    checks++;
    if (bus.posicao !== exp_pos || bus.quote_valid !== 1'b1 || bus.state !== 3'd2) begin
      errors++;
      $display("[TB] FAIL %s_quote: posicao=%b qv=%b state=%0d, wanted posicao=%b qv=1 state=2",
               name, bus.posicao, bus.quote_valid, bus.state, exp_pos);
    end
    if (action == 2) begin
      cnt = 1;
      n = 0;
      @(negedge clk);
      while (bus.state === 3'd2 && n < 100) begin
        cnt++;
        n++;
        @(negedge clk);
      end
      checks++;
      if (cnt < (AT - 1) * TD + 1 || cnt > AT * TD) begin
        errors++;
        $display("[TB] FAIL %s_timeout_len: %0d cycles in WAIT_ACC, wanted %0d..%0d", name, cnt, (AT - 1) * TD + 1, AT * TD);
      end
    end else if (action == 1) begin
      bus.cancel = 1'b1;
      bus.accept = 1'b1;
      @(negedge clk);
      bus.cancel = 1'b0;
      bus.accept = 1'b0;
    end else begin
      bus.accept = 1'b1;
      @(negedge clk);
      bus.accept = 1'b0;
      checks++;
      if (int'(bus.car_pos) != car_model) begin
        errors++;
        $display("[TB] FAIL %s_car_start: car=%0d, wanted %0d", name, bus.car_pos, car_model);
      end
      p = car_model;
      while (p != wo) begin p += (wo > p) ? 1 : -1; path.push_back(p); end
      while (p != wd) begin p += (wd > p) ? 1 : -1; path.push_back(p); end
      prev = car_model;
      done_seen = 1'b0;
      for (int c = 0; c < 300 && !done_seen; c++) begin
        if (bus.state === 3'd5) begin
          done_seen = 1'b1;
        end else begin
          checks++;
          if (bus.grant !== exp_grant || bus.posicao !== exp_pos || bus.quote_valid !== 1'b1 || bus.trip_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_hold: grant=%b posicao=%b qv=%b td=%b state=%0d", name,
                     bus.grant, bus.posicao, bus.quote_valid, bus.trip_done, bus.state);
          end
          if (int'(bus.car_pos) != prev) begin
            ex = (path.size() > 0) ? path.pop_front() : -1;
            checks++;
            if (int'(bus.car_pos) != ex) begin
              errors++;
              $display("[TB] FAIL %s_step: car=%0d, wanted %0d", name, bus.car_pos, ex);
            end
            prev = int'(bus.car_pos);
          end
          bus.cancel = (bus.state === 3'd4) && (always_cancel || $urandom_range(0, 7) == 0);
          @(negedge clk);
        end
      end
      bus.cancel = 1'b0;
      checks++;
      if (!done_seen || bus.trip_done !== 1'b1 || int'(bus.car_pos) != wd || path.size() != 0) begin
        errors++;
        $display("[TB] FAIL %s_done: seen=%b td=%b car=%0d left=%0d, wanted td=1 car=%0d left=0",
                 name, done_seen, bus.trip_done, bus.car_pos, path.size(), wd);
      end
      car_model = wd;
      @(negedge clk);
    end
    checks++;
    if (bus.state !== 3'd0 || bus.grant !== '0 || bus.posicao !== '0 || bus.quote_valid !== 1'b0 ||
        bus.trip_done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_release: state=%0d grant=%b posicao=%b qv=%b td=%b err=%b, wanted all 0",
               name, bus.state, bus.grant, bus.posicao, bus.quote_valid, bus.trip_done, bus.err);
    end
    rr_model = (w + 1) % N;
  endtask

  task automatic test_basic_trip();
    // port 1, pickup 0, destination 8
    run_txn(4'b0010, 16'h0000, 16'h0080, 0, 1'b0, "basic");
    checks++;
    if (bus.car_pos !== 4'd8) begin
      errors++;
      $display("[TB] FAIL basic_final_car: car=%0d, wanted 8", bus.car_pos);
    end
  endtask

  task automatic test_rr_fairness();
    int w;
    logic [3:0] eg;
    bus.orig = 16'h0320;
    bus.dest = 16'h0230;
    bus.req  = 4'b0110;
    for (int t = 0; t < 3; t++) begin
      w  = model_pick(rr_model, 4'b0110);
      eg = 4'(1 << w);
      wait_state(3'd1, 100, "rr_quote");
      checks++;
      if (bus.grant !== eg) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: grant=%b, wanted %b", t, bus.grant, eg);
      end
      @(negedge clk);
      bus.accept = 1'b1;
      @(negedge clk);
      bus.accept = 1'b0;
      wait_state(3'd5, 200, "rr_done");
      if (t == 2) bus.req = '0;
      car_model = (w == 1) ? 3 : 2;
      rr_model = (w + 1) % N;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reject();
    run_txn(4'b1000, 16'h4000, 16'h4000, 0, 1'b0, "same_stop");
    run_txn(4'b1001, 16'h0005, 16'h0001, 0, 1'b0, "after_reject");
    run_txn(4'b0001, 16'h000B, 16'h0002, 0, 1'b0, "orig_range");
  endtask

  task automatic test_timeout();
    run_txn(4'b0100, 16'h0300, 16'h0500, 2, 1'b0, "timeout");
  endtask

  task automatic test_cancel();
    run_txn(4'b0100, 16'h0300, 16'h0500, 1, 1'b0, "cancel_wait");
    run_txn(4'b0010, 16'h0010, 16'h0060, 0, 1'b1, "cancel_trip");
  endtask

  task automatic test_premium();
    run_txn(4'b0010, 16'h0040, 16'h0070, 0, 1'b0, "prem_setup");
    run_txn(4'b0101, 16'h0102, 16'h0305, 1, 1'b0, "prem_pick");
  endtask

  task automatic test_random();
    logic [3:0] rq;
    logic [15:0] o, d;
    for (int t = 0; t < 20; t++) begin
      rq = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        o[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        d[4*i +: 4] = 4'($urandom_range(0, 8));
      end
      run_txn(rq, o, d, int'($urandom_range(0, 2)), 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_trip();
    int o;
    o = (car_model < 4) ? 8 : 0;
    wait_state(3'd0, 200, "rst_idle");
    bus.req  = 4'b0001;
    bus.orig = 16'(o);
    bus.dest = 16'(8 - o);
    @(negedge clk);
    bus.req = '0;
    wait_state(3'd2, 10, "rst_wait");
    bus.accept = 1'b1;
    @(negedge clk);
    bus.accept = 1'b0;
    wait_state(3'd4, 200, "rst_trip");
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.grant, bus.posicao, bus.quote_valid, bus.car_pos, bus.state, bus.trip_done, bus.err} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_trip_reset: grant=%b posicao=%b qv=%b car=%0d state=%0d, wanted all 0",
               bus.grant, bus.posicao, bus.quote_valid, bus.car_pos, bus.state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_model = 0;
    car_model = 0;
    run_txn(4'b0100, 16'h0200, 16'h0100, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_trip();
    test_rr_fairness();
    test_reject();
    test_timeout();
    test_cancel();
    test_premium();
    test_random();
    test_reset_mid_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
